// File: rtl/if_id_buf.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_buf
//  Brief    : Two-entry in-order fetch buffer between instruction fetch and
//             decode. Holds {pc, inst, misalign} and presents the head entry
//             to decode from registers; a redirect (flush) empties it.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_buf #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_inst_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_misalign_o,
    input  logic        id_ready_i,
    output logic [1:0]  buf_count_o,
    output logic [31:0] retire_cnt_o
);

    // Occupancy at which the buffer refuses new entries. Only a depth of two
    // is supported, so 1-bit pointers are sufficient.
    localparam logic [1:0] c_FULL = 2'(DEPTH);

    // Entry storage (data path only, no reset needed: masked by r_count)
    logic [31:0] r_pc   [2];
    logic [31:0] r_inst [2];
    logic        r_mis  [2];

    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;
    logic [31:0] r_retire;

    logic        w_valid;
    logic        w_push;
    logic        w_pop;

    // Handshakes: readiness never looks at decode, so a full buffer cannot
    // pass an entry straight through in the same cycle. Flush kills both.
    assign w_valid       = (r_count != 2'd0);
    assign fetch_ready_o = (r_count < c_FULL);
    assign w_push        = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign w_pop         = w_valid & id_ready_i & ~flush_i;

    // Write the offered entry at the tail; misalignment is captured at fetch
    assign id_valid_o    = w_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]   <= fetch_pc_i;
            r_inst[r_tail] <= fetch_inst_i;
            r_mis[r_tail]  <= (fetch_pc_i[1:0] != 2'b00);
        end
    end

    // Pointer, occupancy and retire-count bookkeeping; reset beats flush,
    // flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
            r_retire <= 32'd0;
        end else if (flush_i) begin
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head   <= ~r_head;
                r_retire <= r_retire + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry toward decode; an empty buffer shows a NOP at pc 0
    always_comb begin
        id_pc_o       = 32'd0;
        id_inst_o     = NOP_INST;
        id_misalign_o = 1'b0;
        if (w_valid) begin
            id_pc_o       = r_pc[r_head];
            id_inst_o     = r_inst[r_head];
            id_misalign_o = r_mis[r_head];
        end
    end

    assign buf_count_o  = r_count;
    assign retire_cnt_o = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_if_id_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_buf
//  Brief    : Self-checking bench for if_id_buf. A queue scoreboard holds the
//             entries the buffer should contain; the head of the queue is
//             compared against the decode-side outputs every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buf;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_inst_i;
    logic        fetch_ready_o;
    logic        flush_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_misalign_o;
    logic        id_ready_i;
    logic [1:0]  buf_count_o;
    logic [31:0] retire_cnt_o;

    entry_t      sb[$];
    logic [31:0] exp_retire;
    int          total = 0;
    int          bad   = 0;

    if_id_buf #(.DEPTH(2), .NOP_INST(c_NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_inst_i  (fetch_inst_i),
        .fetch_ready_o (fetch_ready_o),
        .flush_i       (flush_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_misalign_o (id_misalign_o),
        .id_ready_i    (id_ready_i),
        .buf_count_o   (buf_count_o),
        .retire_cnt_o  (retire_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'h0050_0093 ^ (pc << 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard
    task automatic check_outputs();
        chk("count", 32'(buf_count_o), 32'(sb.size()));
        chk("fetch_ready", 32'(fetch_ready_o), 32'(sb.size() < 2));
        chk("retire", retire_cnt_o, exp_retire);
        if (sb.size() != 0) begin
            chk("id_valid", 32'(id_valid_o), 32'd1);
            chk("id_pc", id_pc_o, sb[0].pc);
            chk("id_inst", id_inst_o, sb[0].inst);
            chk("id_misalign", 32'(id_misalign_o), 32'(sb[0].pc[1:0] != 2'b00));
        end else begin
            chk("idle_valid", 32'(id_valid_o), 32'd0);
            chk("idle_pc", id_pc_o, 32'd0);
            chk("idle_inst", id_inst_o, c_NOP);
            chk("idle_misalign", 32'(id_misalign_o), 32'd0);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the scoreboard to what the rising edge should produce.
    task automatic tick(input logic r, input logic fv, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        logic do_push;
        logic do_pop;
        rst           = r;
        fetch_valid_i = fv;
        fetch_pc_i    = pc;
        fetch_inst_i  = mk_inst(pc);
        id_ready_i    = rdy;
        flush_i       = fl;
        #1;
        check_outputs();
        do_push = fv && (sb.size() < 2) && !fl;
        do_pop  = (sb.size() != 0) && rdy && !fl;
        if (r) begin
            sb.delete();
            exp_retire = 32'd0;
        end else if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                exp_retire = exp_retire + 32'd1;
            end
            if (do_push) sb.push_back('{pc: pc, inst: mk_inst(pc)});
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_pc_i    = 32'd0;
        fetch_inst_i  = 32'd0;
        id_ready_i    = 1'b0;
        flush_i       = 1'b0;
        exp_retire    = 32'd0;
        @(negedge clk);
        @(negedge clk);

        // Reset state, then a first push with decode stalled
        tick(0, 1, 32'h0, 0, 0);
        tick(0, 0, 32'h0, 0, 0);
        chk("first_inst", id_inst_o, 32'h0050_0093);
        tick(0, 0, 32'h0, 1, 0);

        // Fill to two, offer a third while full, then drain in order
        tick(0, 1, 32'h4, 0, 0);
        tick(0, 1, 32'h8, 0, 0);
        tick(0, 1, 32'hC, 0, 0);
        tick(0, 0, 32'h0, 1, 0);
        tick(0, 0, 32'h0, 1, 0);
        tick(0, 0, 32'h0, 0, 0);

        // Streaming: one instruction per cycle, occupancy settles at one
        for (int i = 0; i < 10; i++) tick(0, 1, 32'(i * 4), 1, 0);
        tick(0, 0, 32'h0, 1, 0);

        // Flush a full buffer while a new entry is offered and decode is ready
        tick(0, 1, 32'h40, 0, 0);
        tick(0, 1, 32'h44, 0, 0);
        tick(0, 1, 32'h100, 1, 1);
        tick(0, 1, 32'h100, 0, 0);
        tick(0, 0, 32'h0, 1, 0);

        // Misaligned pc, then a flush on an empty buffer
        tick(0, 1, 32'h102, 0, 0);
        tick(0, 0, 32'h0, 1, 0);
        tick(0, 0, 32'h0, 0, 1);
        tick(0, 0, 32'h0, 0, 0);

        // Random mix of push, pop, stalls and occasional flushes
        for (int i = 0; i < 60; i++) begin
            tick(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Reset mid-operation with a full buffer and a pending offer
        tick(0, 1, 32'h200, 0, 0);
        tick(0, 1, 32'h204, 0, 0);
        tick(1, 1, 32'h208, 1, 0);
        tick(0, 0, 32'h0, 0, 0);
        tick(0, 0, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
